// File: rtl/pcie_pkt_ingress.sv
// ---------------------------------------------------------------------------
// pcie_pkt_ingress
// Upstream feeder of pcie_top. Accepts a 512-bit packet stream and writes its
// flits into the PCIe packet buffer, then one descriptor {queue_id, size} into
// the descriptor buffer with the last flit. A packet is admitted only when
// both buffers have room for a worst-case packet plus the occupancy-report
// lag, so once a packet is admitted it is never stalled.
//
// Optional build macro: PCIE_INGRESS_DROP_ON_FULL_EN
//   defined   : in IDLE the input never stalls; a sop arriving without room
//               discards the whole packet (drop_cnt+1).
//   undefined : a sop arriving without room is held off (in_ready=0).
//
// Ports
//   pcie_clk, pcie_reset_n   clock, asynchronous active-low reset
//   in_data/sop/eop/valid    flit stream input, in_queue_id sampled with sop
//   in_ready                 flit accepted when in_valid && in_ready
//   pcie_pkt_buf_wr_*        packet buffer write {data, sop, eop}, occupancy
//   pcie_desc_buf_wr_*       descriptor write {queue_id, size}, occupancy
//   pkt_cnt                  descriptors written (wraps)
//   drop_cnt                 orphan flits, mid-packet sops, full drops (wraps)
//   trunc_cnt                packets truncated at MAX_FLITS (wraps)
// ---------------------------------------------------------------------------
module pcie_pkt_ingress #(
    parameter int PDU_DEPTH  = 512,
    parameter int PDU_AWIDTH = 9,
    parameter int QID_WIDTH  = 5,
    parameter int MAX_FLITS  = 24,
    parameter int MARGIN     = 4
) (
    input  logic                                       pcie_clk,
    input  logic                                       pcie_reset_n,
    input  logic [511:0]                               in_data,
    input  logic                                       in_sop,
    input  logic                                       in_eop,
    input  logic                                       in_valid,
    input  logic [QID_WIDTH-1:0]                       in_queue_id,
    output logic                                       in_ready,
    output logic [513:0]                               pcie_pkt_buf_wr_data,
    output logic                                       pcie_pkt_buf_wr_en,
    input  logic [PDU_AWIDTH-1:0]                      pcie_pkt_buf_occup,
    output logic [QID_WIDTH+$clog2(MAX_FLITS+1)-1:0]   pcie_desc_buf_wr_data,
    output logic                                       pcie_desc_buf_wr_en,
    input  logic [PDU_AWIDTH-1:0]                      pcie_desc_buf_occup,
    output logic [31:0]                                pkt_cnt,
    output logic [31:0]                                drop_cnt,
    output logic [31:0]                                trunc_cnt
);

    localparam int SIZE_W = $clog2(MAX_FLITS + 1);
    localparam int DESC_W = QID_WIDTH + SIZE_W;
    localparam int SUM_W  = PDU_AWIDTH + 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [QID_WIDTH-1:0]   r_qid, w_qid_nxt;
    logic [SIZE_W-1:0]      r_flit_cnt, w_flit_cnt_nxt;
    logic [SIZE_W-1:0]      w_cnt_plus1;
    logic                   r_pkt_wr_en, w_pkt_wr_en_nxt;
    logic [513:0]           r_pkt_wr_data, w_pkt_wr_data_nxt;
    logic                   r_desc_wr_en, w_desc_wr_en_nxt;
    logic [DESC_W-1:0]      r_desc_wr_data, w_desc_wr_data_nxt;
    logic [31:0]            r_pkt_cnt, r_drop_cnt, r_trunc_cnt;
    logic                   w_pkt_inc, w_drop_inc, w_trunc_inc;
    logic                   w_ready;
    logic                   w_room;
    logic [SUM_W-1:0]       w_pkt_sum, w_desc_sum;

    // Sums are widened so a near-full occupancy cannot wrap and look empty.
    assign w_pkt_sum  = SUM_W'(pcie_pkt_buf_occup) + SUM_W'(MAX_FLITS) + SUM_W'(MARGIN);
    assign w_desc_sum = SUM_W'(pcie_desc_buf_occup) + SUM_W'(MARGIN);
    assign w_room     = (w_pkt_sum < SUM_W'(PDU_DEPTH)) && (w_desc_sum < SUM_W'(PDU_DEPTH));

    assign w_cnt_plus1 = r_flit_cnt + 1'b1;

    always_comb begin
        w_state_nxt        = r_state;
        w_qid_nxt          = r_qid;
        w_flit_cnt_nxt     = r_flit_cnt;
        w_pkt_wr_en_nxt    = 1'b0;
        w_pkt_wr_data_nxt  = r_pkt_wr_data;
        w_desc_wr_en_nxt   = 1'b0;
        w_desc_wr_data_nxt = r_desc_wr_data;
        w_pkt_inc          = 1'b0;
        w_drop_inc         = 1'b0;
        w_trunc_inc        = 1'b0;
        w_ready            = 1'b0;

        case (r_state)
            IDLE: begin
`ifdef PCIE_INGRESS_DROP_ON_FULL_EN
                w_ready = 1'b1;
`else
                w_ready = !in_sop || w_room;
`endif
                if (in_valid && w_ready) begin
                    if (!in_sop) begin
                        w_drop_inc = 1'b1;
                    end
`ifdef PCIE_INGRESS_DROP_ON_FULL_EN
                    else if (!w_room) begin
                        w_drop_inc = 1'b1;
                        // A single-flit packet is already complete; only a
                        // multi-flit packet needs DROP to swallow its tail.
                        if (!in_eop)
                            w_state_nxt = DROP;
                    end
`endif
                    else begin
                        w_qid_nxt         = in_queue_id;
                        w_flit_cnt_nxt    = SIZE_W'(1);
                        w_pkt_wr_en_nxt   = 1'b1;
                        w_pkt_wr_data_nxt = {in_data, 1'b1, in_eop};
                        if (in_eop) begin
                            w_desc_wr_en_nxt   = 1'b1;
                            w_desc_wr_data_nxt = {in_queue_id, SIZE_W'(1)};
                            w_pkt_inc          = 1'b1;
                        end else begin
                            w_state_nxt = FWD;
                        end
                    end
                end
            end

            FWD: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_flit_cnt_nxt    = w_cnt_plus1;
                    w_pkt_wr_en_nxt   = 1'b1;
                    w_pkt_wr_data_nxt = {in_data, 1'b0, 1'b0};
                    if (in_sop)
                        w_drop_inc = 1'b1;
                    if (in_eop) begin
                        w_pkt_wr_data_nxt[0] = 1'b1;
                        w_desc_wr_en_nxt     = 1'b1;
                        w_desc_wr_data_nxt   = {r_qid, w_cnt_plus1};
                        w_pkt_inc            = 1'b1;
                        w_state_nxt          = IDLE;
                    end else if (w_cnt_plus1 == SIZE_W'(MAX_FLITS)) begin
                        // Close the packet early; pkt_cnt counts every
                        // descriptor written, truncated ones included.
                        w_pkt_wr_data_nxt[0] = 1'b1;
                        w_desc_wr_en_nxt     = 1'b1;
                        w_desc_wr_data_nxt   = {r_qid, SIZE_W'(MAX_FLITS)};
                        w_pkt_inc            = 1'b1;
                        w_trunc_inc          = 1'b1;
                        w_state_nxt          = DROP;
                    end
                end
            end

            DROP: begin
                w_ready = 1'b1;
                if (in_valid && in_eop)
                    w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Held low in reset so nothing upstream sees a flit taken.
    assign in_ready = pcie_reset_n && w_ready;

    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            r_state        <= IDLE;
            r_qid          <= '0;
            r_flit_cnt     <= '0;
            r_pkt_wr_en    <= 1'b0;
            r_pkt_wr_data  <= '0;
            r_desc_wr_en   <= 1'b0;
            r_desc_wr_data <= '0;
            r_pkt_cnt      <= '0;
            r_drop_cnt     <= '0;
            r_trunc_cnt    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_qid          <= w_qid_nxt;
            r_flit_cnt     <= w_flit_cnt_nxt;
            r_pkt_wr_en    <= w_pkt_wr_en_nxt;
            r_pkt_wr_data  <= w_pkt_wr_data_nxt;
            r_desc_wr_en   <= w_desc_wr_en_nxt;
            r_desc_wr_data <= w_desc_wr_data_nxt;
            r_pkt_cnt      <= r_pkt_cnt + {31'd0, w_pkt_inc};
            r_drop_cnt     <= r_drop_cnt + {31'd0, w_drop_inc};
            r_trunc_cnt    <= r_trunc_cnt + {31'd0, w_trunc_inc};
        end
    end

    assign pcie_pkt_buf_wr_en    = r_pkt_wr_en;
    assign pcie_pkt_buf_wr_data  = r_pkt_wr_data;
    assign pcie_desc_buf_wr_en   = r_desc_wr_en;
    assign pcie_desc_buf_wr_data = r_desc_wr_data;
    assign pkt_cnt               = r_pkt_cnt;
    assign drop_cnt              = r_drop_cnt;
    assign trunc_cnt             = r_trunc_cnt;

endmodule

// File: doc/pcie_pkt_ingress.md
Name: pcie_pkt_ingress

Overview:
Upstream feeder of pcie_top. Accepts a 512-bit packet stream (sop/eop/valid/ready) with a per-packet queue id, and writes flits into the PCIe packet buffer (pcie_pkt_buf_*). At eop it writes one descriptor into the descriptor buffer (pcie_desc_buf_*). Admission control uses the buffer occupancy counts, so no flit is written without guaranteed room.

Parameters:
PDU_DEPTH, 512, entries in each of the packet and descriptor buffers.
PDU_AWIDTH, 9, occupancy width (clog2 of PDU_DEPTH).
QID_WIDTH, 5, queue id width (APP_IDX_WIDTH).
MAX_FLITS, 24, maximum flits per packet; longer packets are truncated.
MARGIN, 4, extra slack for the occupancy report lag (cycles of write-to-occup latency plus 2).

Ports:
pcie_clk in 1 clock
pcie_reset_n in 1 asynchronous active-low reset
in_data in 512 flit payload
in_sop in 1 first flit of packet
in_eop in 1 last flit of packet
in_valid in 1 flit valid
in_queue_id in QID_WIDTH queue id, sampled with the sop flit
in_ready out 1 flit accepted when in_valid && in_ready
pcie_pkt_buf_wr_data out 514 flit_lite_t {data, sop, eop}
pcie_pkt_buf_wr_en out 1 packet buffer write strobe
pcie_pkt_buf_occup in PDU_AWIDTH packet buffer occupancy
pcie_desc_buf_wr_data out pkt_desc_t {queue_id, size}
pcie_desc_buf_wr_en out 1 descriptor write strobe
pcie_desc_buf_occup in PDU_AWIDTH descriptor buffer occupancy
pkt_cnt out 32 descriptors written, wraps
drop_cnt out 32 packets or flits discarded, wraps
trunc_cnt out 32 packets truncated at MAX_FLITS, wraps

Behaviour:
- Reset (async, pcie_reset_n=0): state=IDLE; in_ready=0; both wr_en=0; wr_data=0; all counters=0; flit_cnt=0. Reset mid-packet abandons the packet and writes nothing further.
- room = (pkt_occup + MAX_FLITS + MARGIN < PDU_DEPTH) && (desc_occup + MARGIN < PDU_DEPTH). Compute the sums in PDU_AWIDTH+6 bits so they cannot overflow.
- The state register updates on the accepted-flit edge; in_ready is combinational from state, room and in_sop.
- IDLE:
  - in_ready = !in_sop || room.
  - Accepted sop flit: latch queue id, write the flit with sop=1, flit_cnt=1.
  - If eop is also set, write the descriptor in the same cycle (size=1) and stay in IDLE; otherwise go to FWD.
  - Accepted non-sop flit (orphan): discard it, drop_cnt+1.
- FWD:
  - in_ready=1, since room was reserved at admission.
  - Each accepted flit is written with sop=0 and flit_cnt+1.
  - A sop seen in FWD is treated as data (sop forced to 0) and drop_cnt+1.
  - On eop: write the flit with eop=1, write the descriptor {latched qid, flit_cnt+1}, pkt_cnt+1, go to IDLE.
  - If flit_cnt+1 == MAX_FLITS without eop: write that flit with eop=1, write the descriptor with size=MAX_FLITS, trunc_cnt+1, go to DROP.
- DROP:
  - in_ready=1; discard flits.
  - On eop, go to IDLE. No descriptor is written and drop_cnt is not incremented.
- Latency: every write strobe is registered, one cycle after the accepting edge. The descriptor strobe coincides with the eop flit strobe.
- size field: flit count of the written packet, 1..MAX_FLITS.
- Strobes are single-cycle; wr_data holds its value when wr_en=0.

Optional Feature:
PCIE_INGRESS_DROP_ON_FULL_EN:
- Defined: in IDLE, in_ready=1 always. A sop arriving while !room goes to DROP (whole packet discarded), drop_cnt+1, and nothing is written.
- Undefined: the default stall behaviour above (in_ready=0 on sop while !room).

Test Plan:
- 4-flit packet, qid=3, buffers empty -> 4 pkt writes over 4 cycles (sop on first, eop on last); one desc write {qid=3, size=4} with the last flit; pkt_cnt=1.
- Single-flit packet (sop=eop=1), qid=7 -> one flit write with sop=eop=1; desc {7,1}; back-to-back single-flit packets accepted every cycle.
- pkt_occup=500 (PDU_DEPTH=512), sop valid -> in_ready=0 and no writes. Drop occup to 400 -> the packet is accepted the next edge. With PCIE_INGRESS_DROP_ON_FULL_EN -> packet discarded, drop_cnt=1.
- 30-flit packet -> 24 flits written, eop on the 24th, desc size=24, trunc_cnt=1; the next 6 flits are discarded; the following packet is handled normally.
- Orphan non-sop flit in IDLE -> no write, drop_cnt=1. A sop in the middle of a 3-flit packet -> written with sop=0, drop_cnt+1, desc size=3.
- pcie_reset_n pulsed low after 2 flits of a 5-flit packet -> outputs 0 immediately, no descriptor written; the next packet after reset yields a correct desc.
